// File: rtl/cic_pkg.sv
// cic_pkg: shared constants and helpers for the I/Q CIC decimator.
//   cic_acc_width() - accumulator width from input width, stage count and rate width
//   MIN_RATE        - smallest decimation factor the counter will accept
//   round_sat()     - add the rounding bit to a truncated value and clamp to a signed range
package cic_pkg;

  localparam int unsigned MIN_RATE = 2;
  // Working width for the round/saturate helper; wide enough for any sane OUT_WIDTH.
  localparam int unsigned CALC_W   = 64;

  // Bit growth of an N-stage CIC at max rate 2^rate_w is N*rate_w bits.
  function automatic int unsigned cic_acc_width(input int unsigned in_w,
                                                input int unsigned stages,
                                                input int unsigned rate_w);
    return in_w + stages * rate_w;
  endfunction

  // trunc_val is the sign-extended truncated sample; rnd_bit is the first dropped bit.
  function automatic logic signed [CALC_W-1:0] round_sat(input logic signed [CALC_W-1:0] trunc_val,
                                                         input logic rnd_bit,
                                                         input int unsigned out_w);
    logic signed [CALC_W-1:0] one_v;
    logic signed [CALC_W-1:0] sum_v;
    logic signed [CALC_W-1:0] max_v;
    logic signed [CALC_W-1:0] min_v;
    one_v = CALC_W'(1);
    max_v = (one_v <<< (out_w - 1)) - one_v;
    min_v = -(one_v <<< (out_w - 1));
    sum_v = trunc_val + (rnd_bit ? one_v : '0);
    if (sum_v > max_v) begin
      return max_v;
    end
    if (sum_v < min_v) begin
      return min_v;
    end
    return sum_v;
  endfunction

endpackage

// File: rtl/cic_channel.sv
// cic_channel: one datapath of the CIC decimator (integrators, combs, output rounding).
//   clock, reset - clock and asynchronous active-high reset
//   dec_i        - decimation event: latch the last integrator into the comb input
//   valid_i      - valid chain from the top; bit k-1 enables comb k, bit STAGES the output
//   data_i       - signed full-rate input sample
//   data_o       - signed rounded/saturated decimated output, held between updates
module cic_channel
  import cic_pkg::*;
#(
  parameter int unsigned IN_WIDTH   = 22,
  parameter int unsigned OUT_WIDTH  = 24,
  parameter int unsigned STAGES     = 5,
  parameter int unsigned RATE_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 dec_i,
  input  logic [STAGES:0]      valid_i,
  input  logic [IN_WIDTH-1:0]  data_i,
  output logic [OUT_WIDTH-1:0] data_o
);

  localparam int unsigned WA    = cic_acc_width(IN_WIDTH, STAGES, RATE_WIDTH);
  localparam int unsigned EXT_W = WA - IN_WIDTH;
  localparam int unsigned PAD_W = CALC_W - OUT_WIDTH;

  logic [WA-1:0]        in_ext_c;
  logic [WA-1:0]        integ_q [STAGES];
  logic [WA-1:0]        integ_d [STAGES];
  logic [WA-1:0]        comb_in_q;
  logic [WA-1:0]        comb_in_d;
  logic [WA-1:0]        comb_q  [STAGES];
  logic [WA-1:0]        comb_d  [STAGES];
  logic [WA-1:0]        dly_q   [STAGES];
  logic [WA-1:0]        dly_d   [STAGES];
  logic [OUT_WIDTH-1:0] trunc_c;
  logic                 round_c;
  logic [OUT_WIDTH-1:0] out_q;
  logic [OUT_WIDTH-1:0] out_d;

  assign in_ext_c = {{EXT_W{data_i[IN_WIDTH-1]}}, data_i};
  assign trunc_c  = comb_q[STAGES-1][WA-1 -: OUT_WIDTH];
  assign round_c  = comb_q[STAGES-1][WA-OUT_WIDTH-1];
  assign data_o   = out_q;

  // Next state: modulo-2^WA integrators every cycle, combs only when their valid bit is set.
  always_comb begin
    integ_d   = integ_q;
    comb_in_d = comb_in_q;
    comb_d    = comb_q;
    dly_d     = dly_q;
    out_d     = out_q;

    integ_d[0] = integ_q[0] + in_ext_c;
    for (int unsigned k = 1; k < STAGES; k++) begin
      integ_d[k] = integ_q[k] + integ_q[k-1];
    end

    if (dec_i) begin
      comb_in_d = integ_q[STAGES-1];
    end

    if (valid_i[0]) begin
      comb_d[0] = comb_in_q - dly_q[0];
      dly_d[0]  = comb_in_q;
    end
    for (int unsigned k = 1; k < STAGES; k++) begin
      if (valid_i[k]) begin
        comb_d[k] = comb_q[k-1] - dly_q[k];
        dly_d[k]  = comb_q[k-1];
      end
    end

    if (valid_i[STAGES]) begin
      out_d = OUT_WIDTH'(round_sat({{PAD_W{trunc_c[OUT_WIDTH-1]}}, trunc_c}, round_c, OUT_WIDTH));
    end
  end

  // State registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        integ_q[k] <= '0;
        comb_q[k]  <= '0;
        dly_q[k]   <= '0;
      end
      comb_in_q <= '0;
      out_q     <= '0;
    end else begin
      integ_q   <= integ_d;
      comb_in_q <= comb_in_d;
      comb_q    <= comb_d;
      dly_q     <= dly_d;
      out_q     <= out_d;
    end
  end

endmodule

// File: rtl/cic_decimator.sv
// cic_decimator: dual-channel (I/Q) N-stage CIC decimator with run-time rate.
//   clock, reset             - clock and asynchronous active-high reset
//   rate                     - decimation factor R (0 and 1 behave as 2)
//   in_data_I, in_data_Q     - signed full-rate samples, one per clock
//   out_data_I, out_data_Q   - signed decimated samples, held between strobes
//   out_strobe               - one-cycle pulse when a new output pair is presented
module cic_decimator
  import cic_pkg::*;
#(
  parameter int unsigned IN_WIDTH   = 22,
  parameter int unsigned OUT_WIDTH  = 24,
  parameter int unsigned STAGES     = 5,
  parameter int unsigned RATE_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [RATE_WIDTH-1:0] rate,
  input  logic [IN_WIDTH-1:0]   in_data_I,
  input  logic [IN_WIDTH-1:0]   in_data_Q,
  output logic [OUT_WIDTH-1:0]  out_data_I,
  output logic [OUT_WIDTH-1:0]  out_data_Q,
  output logic                  out_strobe
);

  localparam logic [RATE_WIDTH-1:0] MIN_R = RATE_WIDTH'(MIN_RATE);

  logic [RATE_WIDTH-1:0] cnt_q;
  logic [RATE_WIDTH-1:0] cnt_d;
  logic [RATE_WIDTH-1:0] rate_q;
  logic [RATE_WIDTH-1:0] rate_d;
  logic [RATE_WIDTH-1:0] rate_clamp_c;
  logic [STAGES:0]       valid_q;
  logic [STAGES:0]       valid_d;
  logic                  strobe_q;
  logic                  strobe_d;
  logic                  dec_c;

  assign rate_clamp_c = (rate < MIN_R) ? MIN_R : rate;
  assign dec_c        = (cnt_q == rate_q - RATE_WIDTH'(1));
  assign out_strobe   = strobe_q;

  // Rate is only sampled at the start of a period so a change never splits one.
  always_comb begin
    cnt_d    = cnt_q + RATE_WIDTH'(1);
    rate_d   = rate_q;
    valid_d  = {valid_q[STAGES-1:0], dec_c};
    strobe_d = valid_q[STAGES];
    if (cnt_q == '0) begin
      rate_d = rate_clamp_c;
    end
    if (dec_c) begin
      cnt_d = '0;
    end
  end

  // Counter, rate and valid-chain registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      rate_q   <= MIN_R;
      valid_q  <= '0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      rate_q   <= rate_d;
      valid_q  <= valid_d;
      strobe_q <= strobe_d;
    end
  end

  cic_channel #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .STAGES    (STAGES),
    .RATE_WIDTH(RATE_WIDTH)
  ) u_chan_i (
    .clock  (clock),
    .reset  (reset),
    .dec_i  (dec_c),
    .valid_i(valid_q),
    .data_i (in_data_I),
    .data_o (out_data_I)
  );

  cic_channel #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .STAGES    (STAGES),
    .RATE_WIDTH(RATE_WIDTH)
  ) u_chan_q (
    .clock  (clock),
    .reset  (reset),
    .dec_i  (dec_c),
    .valid_i(valid_q),
    .data_i (in_data_Q),
    .data_o (out_data_Q)
  );

endmodule

// File: tb/tb_cic_decimator.sv
// tb_cic_decimator: directed self-checking bench for cic_decimator.
module tb_cic_decimator;

  localparam int N    = 5;
  localparam int CH_R = 64;
  localparam int HLEN = N * (CH_R - 1) + 1;

  logic        clock;
  logic        reset;
  logic [7:0]  rate;
  logic [21:0] in_data_I;
  logic [21:0] in_data_Q;
  logic [23:0] out_data_I;
  logic [23:0] out_data_Q;
  logic        out_strobe;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int edge_cnt  = 0;
  int st_t[$];
  int st_i[$];
  int st_q[$];

  cic_decimator #(
    .IN_WIDTH  (22),
    .OUT_WIDTH (24),
    .STAGES    (N),
    .RATE_WIDTH(8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rate      (rate),
    .in_data_I (in_data_I),
    .in_data_Q (in_data_Q),
    .out_data_I(out_data_I),
    .out_data_Q(out_data_Q),
    .out_strobe(out_strobe)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
    edge_cnt++;
  endtask

  // Reset with the given rate and constant inputs; the next posedge is edge 1.
  task automatic do_reset(input logic [7:0] r, input int i_val, input int q_val);
    reset     = 1'b1;
    rate      = r;
    in_data_I = 22'(i_val);
    in_data_Q = 22'(q_val);
    step();
    reset    = 1'b0;
    edge_cnt = 0;
    st_t.delete();
    st_i.delete();
    st_q.delete();
  endtask

  task automatic run_edges(input int n);
    for (int k = 0; k < n; k++) begin
      step();
      if (out_strobe) begin
        st_t.push_back(edge_cnt);
        st_i.push_back(int'($signed(out_data_I)));
        st_q.push_back(int'($signed(out_data_Q)));
      end
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1; rate = 8'd2; in_data_I = '0; in_data_Q = '0;
    #1;
    check_cnt++;
    if (out_data_I !== 24'd0) $display("FAIL por_out_I: got %0d expected 0", out_data_I); else pass_cnt++;
    check_cnt++;
    if (out_data_Q !== 24'd0) $display("FAIL por_out_Q: got %0d expected 0", out_data_Q); else pass_cnt++;
    check_cnt++;
    if (out_strobe !== 1'b0) $display("FAIL por_strobe: got %0b expected 0", out_strobe); else pass_cnt++;

    // Run long enough for non-zero outputs, then reset while an output is in flight.
    do_reset(8'd128, 8000, -8000);
    run_edges(386);
    check_cnt++;
    if (out_data_I === 24'd0) $display("FAIL pre_reset_out_I: got 0 expected non-zero"); else pass_cnt++;
    #3 reset = 1'b1;
    #1;
    check_cnt++;
    if (out_data_I !== 24'd0) $display("FAIL mid_reset_out_I: got %0d expected 0", out_data_I); else pass_cnt++;
    check_cnt++;
    if (out_data_Q !== 24'd0) $display("FAIL mid_reset_out_Q: got %0d expected 0", out_data_Q); else pass_cnt++;
    check_cnt++;
    if (out_strobe !== 1'b0) $display("FAIL mid_reset_strobe: got %0b expected 0", out_strobe); else pass_cnt++;

    rate = 8'd10;
    step();
    reset    = 1'b0;
    edge_cnt = 0;
    n = 0;
    do begin
      step();
      n++;
    end while (!out_strobe && n < 40);
    check_cnt++;
    if (n !== 16 || out_strobe !== 1'b1)
      $display("FAIL first_strobe_after_reset: got edge %0d (strobe %0b) expected edge 16", n, out_strobe);
    else pass_cnt++;
  endtask

  task automatic test_cadence(input logic [7:0] r, input int first, input int space);
    do_reset(r, 1000, 1000);
    run_edges(first + 3 * space);
    check_cnt++;
    if (st_t.size() !== 4) $display("FAIL cadence_count rate=%0d: got %0d expected 4", r, st_t.size()); else pass_cnt++;
    if (st_t.size() > 0) begin
      check_cnt++;
      if (st_t[0] !== first) $display("FAIL cadence_first rate=%0d: got %0d expected %0d", r, st_t[0], first);
      else pass_cnt++;
    end
    for (int k = 1; k < st_t.size(); k++) begin
      check_cnt++;
      if (st_t[k] - st_t[k-1] !== space)
        $display("FAIL cadence_space rate=%0d: got %0d expected %0d", r, st_t[k] - st_t[k-1], space);
      else pass_cnt++;
    end
  endtask

  task automatic test_dc_gain();
    do_reset(8'd128, 8000, -8000);
    run_edges(128 * 9 + 6);
    check_cnt++;
    if (st_t.size() !== 9) $display("FAIL dc_count: got %0d expected 9", st_t.size()); else pass_cnt++;
    for (int k = 6; k < 9 && k < st_t.size(); k++) begin
      check_cnt++;
      if (st_i[k] !== 1000) $display("FAIL dc_out_I[%0d]: got %0d expected 1000", k, st_i[k]); else pass_cnt++;
      check_cnt++;
      if (st_q[k] !== -1000) $display("FAIL dc_out_Q[%0d]: got %0d expected -1000", k, st_q[k]); else pass_cnt++;
    end
    run_edges(3);
    check_cnt++;
    if (out_strobe !== 1'b0) $display("FAIL dc_strobe_width: got %0b expected 0", out_strobe); else pass_cnt++;
    check_cnt++;
    if (int'($signed(out_data_I)) !== 1000)
      $display("FAIL dc_hold_I: got %0d expected 1000", $signed(out_data_I));
    else pass_cnt++;
  endtask

  task automatic test_rate_change();
    do_reset(8'd128, 8192, -8192);
    run_edges(1100);
    rate = 8'd64;
    run_edges(600);
    check_cnt++;
    if (st_t.size() !== 17) $display("FAIL rc_count: got %0d expected 17", st_t.size()); else pass_cnt++;
    if (st_t.size() == 17) begin
      check_cnt++;
      if (st_t[8] !== 1158) $display("FAIL rc_last_long: got %0d expected 1158", st_t[8]); else pass_cnt++;
      check_cnt++;
      if (st_t[8] - st_t[7] !== 128) $display("FAIL rc_space_old: got %0d expected 128", st_t[8] - st_t[7]); else pass_cnt++;
      check_cnt++;
      if (st_t[9] - st_t[8] !== 64) $display("FAIL rc_space_new: got %0d expected 64", st_t[9] - st_t[8]); else pass_cnt++;
      check_cnt++;
      if (st_t[16] !== 1670) $display("FAIL rc_last_strobe: got %0d expected 1670", st_t[16]); else pass_cnt++;
      check_cnt++;
      if (st_i[8] !== 1024) $display("FAIL rc_old_out_I: got %0d expected 1024", st_i[8]); else pass_cnt++;
      for (int k = 13; k < 17; k++) begin
        check_cnt++;
        if (st_i[k] !== 32) $display("FAIL rc_out_I[%0d]: got %0d expected 32", k, st_i[k]); else pass_cnt++;
        check_cnt++;
        if (st_q[k] !== -32) $display("FAIL rc_out_Q[%0d]: got %0d expected -32", k, st_q[k]); else pass_cnt++;
      end
    end
  endtask

  task automatic test_wrap();
    do_reset(8'd255, -2097152, 2097151);
    run_edges(255 * 9 + 6);
    check_cnt++;
    if (st_t.size() !== 9) $display("FAIL wrap_count: got %0d expected 9", st_t.size()); else pass_cnt++;
    for (int k = 5; k < st_t.size(); k++) begin
      check_cnt++;
      if (st_i[k] !== -8226043) $display("FAIL wrap_out_I[%0d]: got %0d expected -8226043", k, st_i[k]); else pass_cnt++;
      check_cnt++;
      if (st_q[k] !== 8226039) $display("FAIL wrap_out_Q[%0d]: got %0d expected 8226039", k, st_q[k]); else pass_cnt++;
    end
  endtask

  // Random I against a direct-form model: y = sum h[j]*x(e-N-j), h = boxcar(R)^N.
  task automatic test_channel_indep();
    longint h   [HLEN];
    longint tmp [HLEN];
    int     xs  [800];
    int     hl;
    int     m;
    int     e;
    int     idx;
    int     exp_i;
    longint y;
    for (int j = 0; j < HLEN; j++) h[j] = (j < CH_R) ? 64'sd1 : 64'sd0;
    hl = CH_R;
    repeat (N - 1) begin
      for (int j = 0; j < HLEN; j++) tmp[j] = 0;
      for (int i = 0; i < hl; i++)
        for (int k = 0; k < CH_R; k++) tmp[i+k] += h[i];
      hl += CH_R - 1;
      for (int j = 0; j < HLEN; j++) h[j] = tmp[j];
    end
    xs[0] = 0;
    for (int n = 1; n < 800; n++) xs[n] = int'($urandom_range(0, 4194303)) - 2097152;

    do_reset(8'(CH_R), 0, 0);
    m = 0;
    for (int n = 1; n <= CH_R * 12 + N + 1; n++) begin
      in_data_I = 22'(xs[n]);
      step();
      if (out_strobe) begin
        m++;
        e = n - N - 1;
        check_cnt++;
        if (n !== CH_R * m + N + 1) $display("FAIL ch_strobe_time[%0d]: got %0d expected %0d", m, n, CH_R * m + N + 1);
        else pass_cnt++;
        y = 0;
        for (int j = 0; j < HLEN; j++) begin
          idx = e - N - j;
          if (idx >= 1) y += h[j] * longint'(xs[idx]);
        end
        exp_i = int'((y + (64'sd1 <<< 37)) >>> 38);
        check_cnt++;
        if (int'($signed(out_data_I)) !== exp_i)
          $display("FAIL ch_out_I[%0d]: got %0d expected %0d", m, $signed(out_data_I), exp_i);
        else pass_cnt++;
        check_cnt++;
        if (out_data_Q !== 24'd0) $display("FAIL ch_out_Q[%0d]: got %0d expected 0", m, out_data_Q); else pass_cnt++;
      end
    end
    check_cnt++;
    if (m !== 12) $display("FAIL ch_count: got %0d expected 12", m); else pass_cnt++;
  endtask

  initial begin
    reset     = 1'b1;
    rate      = 8'd2;
    in_data_I = '0;
    in_data_Q = '0;
    test_reset();
    test_cadence(8'd10, 16, 10);
    test_cadence(8'd0, 8, 2);
    test_cadence(8'd1, 8, 2);
    test_dc_gain();
    test_rate_change();
    test_wrap();
    test_channel_indep();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
